// File: rtl/bus_cycle_responder.sv
// Terminates decoded 68k bus cycles: DTACK after per-select wait states or device ready,
// BERR on bad decode or timeout. Outputs are registered; cycle held until AS negates.
module bus_cycle_responder #(
  parameter int                     NUM_SELECTS  = 8,
  parameter int                     WAIT_W       = 4,
  parameter logic [NUM_SELECTS-1:0] EXT_MASK     = '0,
  parameter int                     BERR_TIMEOUT = 64
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            as_n,
  input  logic [NUM_SELECTS-1:0]          cs,
  input  logic [NUM_SELECTS*WAIT_W-1:0]   waits,
  input  logic [NUM_SELECTS-1:0]          ready,
  output logic                            dtack_n,
  output logic                            berr_n,
  output logic                            busy,
  output logic [$clog2(NUM_SELECTS)-1:0]  sel_idx
);

  localparam int SEL_W = $clog2(NUM_SELECTS);
  localparam int TMO_W = $clog2(BERR_TIMEOUT) + 1;
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(BERR_TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE,
    WAIT,
    ACK,
    ERR,
    RELEASE
  } state_t;

  state_t            state;
  logic [WAIT_W-1:0] wcnt;
  logic [TMO_W-1:0]  tmo;
  logic              ext_mode;

  logic [SEL_W-1:0]  cs_idx;
  logic              cs_onehot;
  logic [WAIT_W-1:0] cs_waits;
  logic              wait_done;

  // Lowest set bit wins; only meaningful when cs is one-hot.
  always_comb begin
    cs_idx = '0;
    for (int i = NUM_SELECTS - 1; i >= 0; i--) begin
      if (cs[i]) cs_idx = SEL_W'(i);
    end
  end

  assign cs_onehot = (cs != '0) && ((cs & (cs - NUM_SELECTS'(1))) == '0);
  assign cs_waits  = waits[int'(cs_idx)*WAIT_W +: WAIT_W];
  assign wait_done = ext_mode ? ready[sel_idx] : (wcnt == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      dtack_n  <= 1'b1;
      berr_n   <= 1'b1;
      busy     <= 1'b0;
      sel_idx  <= '0;
      wcnt     <= '0;
      tmo      <= '0;
      ext_mode <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (!as_n) begin
            sel_idx  <= cs_idx;
            busy     <= 1'b1;
            tmo      <= '0;
            ext_mode <= EXT_MASK[cs_idx];
            if (!cs_onehot) begin
              state <= ERR;
            end else begin
              state <= WAIT;
              wcnt  <= EXT_MASK[cs_idx] ? '0 : cs_waits;
            end
          end
        end

        // Abort beats termination; termination beats timeout on the same edge.
        WAIT: begin
          if (as_n) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else if (wait_done) begin
            state   <= ACK;
            dtack_n <= 1'b0;
          end else if (tmo == TMO_LAST) begin
            state  <= ERR;
            berr_n <= 1'b0;
          end else begin
            if (wcnt != '0) wcnt <= wcnt - WAIT_W'(1);
            if (tmo != '1)  tmo  <= tmo + TMO_W'(1);
          end
        end

        ACK: begin
          if (as_n) begin
            state   <= RELEASE;
            dtack_n <= 1'b1;
            busy    <= 1'b0;
          end else begin
            dtack_n <= 1'b0;
          end
        end

        // Entered straight from IDLE on a bad decode, so BERR lands one edge after accept.
        ERR: begin
          if (as_n) begin
            state  <= RELEASE;
            berr_n <= 1'b1;
            busy   <= 1'b0;
          end else begin
            berr_n <= 1'b0;
          end
        end

        RELEASE: begin
          state   <= IDLE;
          dtack_n <= 1'b1;
          berr_n  <= 1'b1;
          busy    <= 1'b0;
        end

        default: begin
          state   <= IDLE;
          dtack_n <= 1'b1;
          berr_n  <= 1'b1;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule
